// File: rtl/imsic_csr_arb.sv
// Round-robin arbiter that shares the IMSIC interrupt-file CSR port among NR_REQ requesters.
// Latency: accept T, CSR access T+1, response T+3 (local reject T+1, timeout T+2+TIMEOUT_CYC).
// Backpressure: one access in flight; pending requests wait on req_rdy; responses cannot be stalled.
module imsic_csr_arb #(
    parameter int NR_REQ          = 2,
    parameter int XLEN            = 64,
    parameter int NR_INTP_FILES   = 7,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int TIMEOUT_CYC     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NR_REQ-1:0]                 req_vld,
    output logic [NR_REQ-1:0]                 req_rdy,
    input  logic [NR_REQ-1:0]                 req_wr,
    input  logic [NR_REQ*12-1:0]              req_addr,
    input  logic [NR_REQ*2-1:0]               req_op,
    input  logic [NR_REQ*XLEN-1:0]            req_wdata,
    input  logic [NR_REQ-1:0]                 req_v,
    input  logic [NR_REQ*INTP_FILE_WIDTH-1:0] req_file_sel,
    output logic [NR_REQ-1:0]                 rsp_vld,
    output logic [XLEN-1:0]                   rsp_rdata,
    output logic                              rsp_illegal,
    output logic [11:0]                       csr_addr,
    output logic                              csr_rd,
    output logic                              csr_wdata_vld,
    output logic [1:0]                        csr_wdata_op,
    output logic [XLEN-1:0]                   csr_wdata,
    output logic                              csr_v,
    output logic [INTP_FILE_WIDTH-1:0]        intp_file_sel,
    input  logic                              csr_rdata_vld,
    input  logic [XLEN-1:0]                   csr_rdata,
    input  logic                              csr_illegal
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [INTP_FILE_WIDTH:0] NR_FILES = (INTP_FILE_WIDTH + 1)'(NR_INTP_FILES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NR_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                     state, state_nxt;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           cur_g;
    logic [CNT_W-1:0]           to_cnt;

    logic                       gnt_any;
    logic [PTR_W-1:0]           gnt_idx;
    logic                       gnt_bad;

    logic                       lat_wr;
    logic [11:0]                lat_addr;
    logic [1:0]                 lat_op;
    logic [XLEN-1:0]            lat_wdata;
    logic                       lat_v;
    logic [INTP_FILE_WIDTH-1:0] lat_file;
    logic [XLEN-1:0]            cap_rdata;
    logic                       cap_illegal;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping upward
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NR_REQ) begin
                j = j - NR_REQ;
            end
            if (!gnt_any && req_vld[PTR_W'(j)]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(j);
            end
        end
        gnt_bad = ({1'b0, req_file_sel[int'(gnt_idx)*INTP_FILE_WIDTH +: INTP_FILE_WIDTH]} >= NR_FILES);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_any) state_nxt = gnt_bad ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (csr_rdata_vld || (to_cnt == CNT_LAST)) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload latch, completion capture, timeout counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cur_g       <= '0;
            to_cnt      <= '0;
            lat_wr      <= 1'b0;
            lat_addr    <= '0;
            lat_op      <= '0;
            lat_wdata   <= '0;
            lat_v       <= 1'b0;
            lat_file    <= '0;
            cap_rdata   <= '0;
            cap_illegal <= 1'b0;
        end else begin
            to_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        cur_g     <= gnt_idx;
                        lat_wr    <= req_wr[gnt_idx];
                        lat_addr  <= req_addr[int'(gnt_idx)*12 +: 12];
                        lat_op    <= req_op[int'(gnt_idx)*2 +: 2];
                        lat_wdata <= req_wdata[int'(gnt_idx)*XLEN +: XLEN];
                        lat_v     <= req_v[gnt_idx];
                        lat_file  <= req_file_sel[int'(gnt_idx)*INTP_FILE_WIDTH +: INTP_FILE_WIDTH];
                        // A bad file select is answered locally without touching the register block
                        cap_rdata   <= '0;
                        cap_illegal <= gnt_bad;
                    end
                end
                S_WAIT: begin
                    if (csr_rdata_vld) begin
                        cap_rdata   <= csr_rdata;
                        cap_illegal <= csr_illegal;
                    end else if (to_cnt == CNT_LAST) begin
                        cap_rdata   <= '0;
                        cap_illegal <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (cur_g == PTR_LAST) ? '0 : cur_g + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state: grant strobe, response strobe, CSR port drive
    always_comb begin
        req_rdy       = '0;
        rsp_vld       = '0;
        rsp_rdata     = '0;
        rsp_illegal   = 1'b0;
        csr_addr      = '0;
        csr_rd        = 1'b0;
        csr_wdata_vld = 1'b0;
        csr_wdata_op  = '0;
        csr_wdata     = '0;
        csr_v         = 1'b0;
        intp_file_sel = '0;
        if (state == S_IDLE && gnt_any && !rst) begin
            req_rdy[gnt_idx] = 1'b1;
        end
        if (state == S_RESP) begin
            rsp_vld[cur_g] = 1'b1;
            rsp_rdata      = cap_rdata;
            rsp_illegal    = cap_illegal;
        end
        if (state == S_ISSUE) begin
            csr_addr      = lat_addr;
            csr_rd        = 1'b1;
            csr_wdata_vld = lat_wr;
            csr_wdata_op  = lat_op;
            csr_wdata     = lat_wdata;
            csr_v         = lat_v;
            intp_file_sel = lat_file;
        end
    end

endmodule

// File: tb/tb_imsic_csr_arb.sv
// Directed bench for imsic_csr_arb with a one-cycle-latency register block model.
// Latency: checks exact cycle of grant, CSR access and response for each scenario.
// Backpressure: requesters always sink responses; grants observed via req_rdy.
module tb_imsic_csr_arb;

    localparam int NR_REQ          = 2;
    localparam int XLEN            = 64;
    localparam int NR_INTP_FILES   = 7;
    localparam int INTP_FILE_WIDTH = 3;
    localparam int TIMEOUT_CYC     = 4;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic [NR_REQ-1:0]                 req_vld = '0;
    logic [NR_REQ-1:0]                 req_rdy;
    logic [NR_REQ-1:0]                 req_wr = '0;
    logic [NR_REQ*12-1:0]              req_addr = '0;
    logic [NR_REQ*2-1:0]               req_op = '0;
    logic [NR_REQ*XLEN-1:0]            req_wdata = '0;
    logic [NR_REQ-1:0]                 req_v = '0;
    logic [NR_REQ*INTP_FILE_WIDTH-1:0] req_file_sel = '0;
    logic [NR_REQ-1:0]                 rsp_vld;
    logic [XLEN-1:0]                   rsp_rdata;
    logic                              rsp_illegal;
    logic [11:0]                       csr_addr;
    logic                              csr_rd;
    logic                              csr_wdata_vld;
    logic [1:0]                        csr_wdata_op;
    logic [XLEN-1:0]                   csr_wdata;
    logic                              csr_v;
    logic [INTP_FILE_WIDTH-1:0]        intp_file_sel;
    logic                              csr_rdata_vld = 1'b0;
    logic [XLEN-1:0]                   csr_rdata = '0;
    logic                              csr_illegal = 1'b0;

    logic            model_en   = 1'b1;
    logic            inject_vld = 1'b0;
    logic [XLEN-1:0] model_data = '0;
    logic            model_ill  = 1'b0;

    int checks   = 0;
    int failures = 0;

    imsic_csr_arb #(
        .NR_REQ(NR_REQ), .XLEN(XLEN), .NR_INTP_FILES(NR_INTP_FILES),
        .INTP_FILE_WIDTH(INTP_FILE_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_op(req_op), .req_wdata(req_wdata), .req_v(req_v), .req_file_sel(req_file_sel),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wdata_vld(csr_wdata_vld),
        .csr_wdata_op(csr_wdata_op), .csr_wdata(csr_wdata), .csr_v(csr_v),
        .intp_file_sel(intp_file_sel), .csr_rdata_vld(csr_rdata_vld),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    // Register block model: completion one cycle after csr_rd, plus a stray-strobe injector
    always @(posedge clk) begin
        csr_rdata_vld <= (model_en && csr_rd) || inject_vld;
        csr_rdata     <= model_data;
        csr_illegal   <= model_ill;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [11:0] addr, input logic [1:0] op,
                           input logic [XLEN-1:0] wd, input logic v, input logic [INTP_FILE_WIDTH-1:0] fs);
        req_wr[r]                                        = wr;
        req_addr[r*12 +: 12]                             = addr;
        req_op[r*2 +: 2]                                 = op;
        req_wdata[r*XLEN +: XLEN]                        = wd;
        req_v[r]                                         = v;
        req_file_sel[r*INTP_FILE_WIDTH +: INTP_FILE_WIDTH] = fs;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 2'b11;
        step(); step();
        checks++; if (req_rdy !== 2'b00) begin failures++; $display("FAIL reset_req_rdy got=%0h exp=0", req_rdy); end
        checks++; if (rsp_vld !== 2'b00) begin failures++; $display("FAIL reset_rsp_vld got=%0h exp=0", rsp_vld); end
        checks++; if (rsp_rdata !== 64'h0 || rsp_illegal !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%0h/%0b exp=0/0", rsp_rdata, rsp_illegal); end
        checks++; if ({csr_rd, csr_wdata_vld, csr_v, csr_wdata_op, csr_addr, intp_file_sel} !== 19'h0 || csr_wdata !== 64'h0)
            begin failures++; $display("FAIL reset_csr got rd=%0b addr=%0h wd=%0h exp=all 0", csr_rd, csr_addr, csr_wdata); end
        req_vld = 2'b00; rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        model_en = 1'b1; model_data = 64'h1; model_ill = 1'b0;
        set_req(0, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd1);
        req_vld = 2'b01; #1;
        checks++; if (req_rdy !== 2'b01) begin failures++; $display("FAIL rd_rdy got=%0h exp=1", req_rdy); end
        step(); req_vld = 2'b00; #1;
        checks++; if (csr_rd !== 1'b1 || csr_addr !== 12'h070 || intp_file_sel !== 3'd1 || csr_wdata_vld !== 1'b0 || csr_wdata_op !== 2'b01)
            begin failures++; $display("FAIL rd_issue got rd=%0b addr=%0h file=%0d wv=%0b op=%0b exp 1/70/1/0/01", csr_rd, csr_addr, intp_file_sel, csr_wdata_vld, csr_wdata_op); end
        step();
        checks++; if (csr_rd !== 1'b0 || rsp_vld !== 2'b00) begin failures++; $display("FAIL rd_wait got rd=%0b rsp=%0h exp 0/0", csr_rd, rsp_vld); end
        step();
        checks++; if (rsp_vld !== 2'b01 || rsp_rdata !== 64'h1 || rsp_illegal !== 1'b0)
            begin failures++; $display("FAIL rd_resp got vld=%0h data=%0h ill=%0b exp 1/1/0", rsp_vld, rsp_rdata, rsp_illegal); end
        step();
        checks++; if (rsp_vld !== 2'b00) begin failures++; $display("FAIL rd_resp_once got=%0h exp=0", rsp_vld); end
    endtask

    task automatic test_write_set();
        model_data = 64'h55;
        set_req(1, 1'b1, 12'h0C0, 2'b10, 64'h6, 1'b1, 3'd2);
        req_vld = 2'b10; #1;
        checks++; if (req_rdy !== 2'b10) begin failures++; $display("FAIL wr_rdy got=%0h exp=2", req_rdy); end
        step(); req_vld = 2'b00; #1;
        checks++; if (csr_rd !== 1'b1 || csr_wdata_vld !== 1'b1 || csr_wdata_op !== 2'b10 || csr_wdata !== 64'h6 ||
                      csr_addr !== 12'h0C0 || csr_v !== 1'b1 || intp_file_sel !== 3'd2)
            begin failures++; $display("FAIL wr_issue got rd=%0b wv=%0b op=%0b wd=%0h addr=%0h v=%0b file=%0d exp 1/1/10/6/c0/1/2", csr_rd, csr_wdata_vld, csr_wdata_op, csr_wdata, csr_addr, csr_v, intp_file_sel); end
        step();
        checks++; if (csr_rd !== 1'b0 || csr_wdata_vld !== 1'b0 || csr_wdata !== 64'h0) begin failures++; $display("FAIL wr_csr_idle got rd=%0b wv=%0b wd=%0h exp 0/0/0", csr_rd, csr_wdata_vld, csr_wdata); end
        step();
        checks++; if (rsp_vld !== 2'b10 || rsp_rdata !== 64'h55) begin failures++; $display("FAIL wr_resp got vld=%0h data=%0h exp 2/55", rsp_vld, rsp_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy, exp_rsp;
        rst = 1'b1; step(); step();
        set_req(0, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd0);
        set_req(1, 1'b0, 12'h071, 2'b01, 64'h0, 1'b0, 3'd0);
        rst = 1'b0; req_vld = 2'b11; #1;
        for (int c = 0; c < 16; c++) begin
            exp_rdy = (c % 4 == 0) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (req_rdy !== exp_rdy) begin failures++; $display("FAIL b2b_rdy c=%0d got=%0h exp=%0h", c, req_rdy, exp_rdy); end
            checks++; if (rsp_vld !== exp_rsp) begin failures++; $display("FAIL b2b_rsp c=%0d got=%0h exp=%0h", c, rsp_vld, exp_rsp); end
            step();
        end
        req_vld = 2'b00;
        step();
    endtask

    task automatic test_reject();
        model_data = 64'hDEAD;
        set_req(0, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd7);
        req_vld = 2'b01; #1;
        checks++; if (req_rdy !== 2'b01) begin failures++; $display("FAIL rej_rdy got=%0h exp=1", req_rdy); end
        step(); req_vld = 2'b00; #1;
        checks++; if (rsp_vld !== 2'b01 || rsp_illegal !== 1'b1 || rsp_rdata !== 64'h0 || csr_rd !== 1'b0)
            begin failures++; $display("FAIL rej_resp got vld=%0h ill=%0b data=%0h rd=%0b exp 1/1/0/0", rsp_vld, rsp_illegal, rsp_rdata, csr_rd); end
        step();
        set_req(1, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd6);
        req_vld = 2'b10; #1;
        checks++; if (req_rdy !== 2'b10 || rsp_vld !== 2'b00) begin failures++; $display("FAIL rej_next_rdy got rdy=%0h rsp=%0h exp 2/0", req_rdy, rsp_vld); end
        step(); req_vld = 2'b00; #1;
        checks++; if (csr_rd !== 1'b1 || intp_file_sel !== 3'd6) begin failures++; $display("FAIL file6_issue got rd=%0b file=%0d exp 1/6", csr_rd, intp_file_sel); end
        step(); step();
        checks++; if (rsp_vld !== 2'b10 || rsp_rdata !== 64'hDEAD || rsp_illegal !== 1'b0)
            begin failures++; $display("FAIL file6_resp got vld=%0h data=%0h ill=%0b exp 2/dead/0", rsp_vld, rsp_rdata, rsp_illegal); end
        step();
    endtask

    task automatic test_timeout();
        model_en = 1'b0; model_data = 64'hBEEF;
        set_req(0, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd0);
        req_vld = 2'b01; #1;
        checks++; if (req_rdy !== 2'b01) begin failures++; $display("FAIL to_rdy got=%0h exp=1", req_rdy); end
        step(); req_vld = 2'b00; #1;
        checks++; if (csr_rd !== 1'b1) begin failures++; $display("FAIL to_issue got=%0b exp=1", csr_rd); end
        for (int k = 2; k <= 5; k++) begin
            step();
            checks++; if (rsp_vld !== 2'b00) begin failures++; $display("FAIL to_wait k=%0d got=%0h exp=0", k, rsp_vld); end
        end
        step();
        checks++; if (rsp_vld !== 2'b01 || rsp_illegal !== 1'b1 || rsp_rdata !== 64'h0)
            begin failures++; $display("FAIL to_resp got vld=%0h ill=%0b data=%0h exp 1/1/0", rsp_vld, rsp_illegal, rsp_rdata); end
        inject_vld = 1'b1;
        step(); inject_vld = 1'b0;
        checks++; if (rsp_vld !== 2'b00 || csr_rd !== 1'b0) begin failures++; $display("FAIL to_late_t7 got vld=%0h rd=%0b exp 0/0", rsp_vld, csr_rd); end
        step();
        checks++; if (rsp_vld !== 2'b00) begin failures++; $display("FAIL to_late_t8 got=%0h exp=0", rsp_vld); end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        model_data = 64'h77;
        set_req(0, 1'b0, 12'h070, 2'b01, 64'h0, 1'b0, 3'd0);
        req_vld = 2'b01; #1;
        checks++; if (req_rdy !== 2'b01) begin failures++; $display("FAIL rm_rdy got=%0h exp=1", req_rdy); end
        step();
        set_req(1, 1'b0, 12'h071, 2'b01, 64'h0, 1'b0, 3'd0);
        req_vld = 2'b11; #1;
        checks++; if (csr_rd !== 1'b1 || req_rdy !== 2'b00) begin failures++; $display("FAIL rm_issue got rd=%0b rdy=%0h exp 1/0", csr_rd, req_rdy); end
        step();
        rst = 1'b1; inject_vld = 1'b1; #1;
        checks++; if (req_rdy !== 2'b00) begin failures++; $display("FAIL rm_rst_rdy got=%0h exp=0", req_rdy); end
        step();
        rst = 1'b0; inject_vld = 1'b0; #1;
        checks++; if (rsp_vld !== 2'b00 || rsp_rdata !== 64'h0 || rsp_illegal !== 1'b0 || csr_rd !== 1'b0 || csr_addr !== 12'h0)
            begin failures++; $display("FAIL rm_after_rst got vld=%0h data=%0h ill=%0b rd=%0b addr=%0h exp all 0", rsp_vld, rsp_rdata, rsp_illegal, csr_rd, csr_addr); end
        checks++; if (req_rdy !== 2'b01) begin failures++; $display("FAIL rm_prio got=%0h exp=1", req_rdy); end
        step(); req_vld = 2'b10; #1;
        checks++; if (csr_rd !== 1'b1 || req_rdy !== 2'b00 || rsp_vld !== 2'b00) begin failures++; $display("FAIL rm_reissue got rd=%0b rdy=%0h rsp=%0h exp 1/0/0", csr_rd, req_rdy, rsp_vld); end
        step();
        checks++; if (rsp_vld !== 2'b00) begin failures++; $display("FAIL rm_wait got=%0h exp=0", rsp_vld); end
        step();
        checks++; if (rsp_vld !== 2'b01 || rsp_rdata !== 64'h77) begin failures++; $display("FAIL rm_resp got vld=%0h data=%0h exp 1/77", rsp_vld, rsp_rdata); end
        step();
        checks++; if (req_rdy !== 2'b10) begin failures++; $display("FAIL rm_req1_rdy got=%0h exp=2", req_rdy); end
        step(); req_vld = 2'b00;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_set();
        test_back_to_back();
        test_reject();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imsic_csr_arb.md
# imsic_csr_arb

Round-robin arbiter and sequencer that shares the single IMSIC interrupt-file CSR port among NR_REQ requesters (e.g. hart CSR unit, debug/config port). It accepts one request at a time and issues it to the CSR register block as a one-cycle access. It waits for that block's registered completion, then returns read data and the illegal flag to the granted requester. It sits between the requester fabric and the IMSIC CSR register block and is the only driver of that block's CSR inputs.

## Interface
- NR_REQ, 2, number of requesters (2..8)
- XLEN, 64, CSR data width (32 or 64)
- NR_INTP_FILES, 7, implemented interrupt files; file selects at or above this are rejected locally
- INTP_FILE_WIDTH, 3, width of file select
- TIMEOUT_CYC, 4, max WAIT cycles before a forced illegal response (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_vld  in  NR_REQ  request valid per requester; held until accepted
- req_rdy  out  NR_REQ  accept strobe, one-hot, combinational
- req_wr  in  NR_REQ  1 = write (csrrw/rs/rc), 0 = read
- req_addr  in  NR_REQ*12  CSR offset, slice r = [12r+11:12r]
- req_op  in  NR_REQ*2  01 rw, 10 set, 11 clr, 00 illegal
- req_wdata  in  NR_REQ*XLEN  write data
- req_v  in  NR_REQ  virtualization mode bit
- req_file_sel  in  NR_REQ*INTP_FILE_WIDTH  target interrupt file
- rsp_vld  out  NR_REQ  one-cycle response strobe to granted requester
- rsp_rdata  out  XLEN  response data, shared, valid with rsp_vld
- rsp_illegal  out  1  response illegal flag, shared
- csr_addr, csr_rd, csr_wdata_vld, csr_wdata_op, csr_wdata, csr_v, intp_file_sel  out  12/1/1/2/XLEN/1/INTP_FILE_WIDTH  CSR port to the register block
- csr_rdata_vld, csr_rdata, csr_illegal  in  1/XLEN/1  completion from the register block

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant the first req_vld at or after rr_ptr, scanning upward with wrap.
  - Assert req_rdy[g] for that cycle. Latch its payload and g.
  - If req_file_sel >= NR_INTP_FILES, go to RESP with illegal=1 and rdata=0. No CSR access is issued.
  - Otherwise go to ISSUE.
- ISSUE, one cycle:
  - csr_rd=1.
  - csr_wdata_vld = latched wr.
  - Other csr_* outputs = latched payload.
  - Go to WAIT.
- WAIT:
  - On csr_rdata_vld: capture csr_rdata/csr_illegal, go to RESP.
  - Else increment the timeout counter. When the counter reaches TIMEOUT_CYC-1, go to RESP with illegal=1 and rdata=0.
- RESP, one cycle:
  - rsp_vld[g]=1, rsp_rdata/rsp_illegal from captures.
  - Writes return rdata as captured; requesters ignore it.
  - rr_ptr <= (g+1) mod NR_REQ.
  - Go to IDLE.
- csr_* outputs (all fields) are 0 outside ISSUE.
- The op is passed through unchanged. Legality of op/addr/privilege belongs to the register block; illegal results are reported via csr_illegal.
- A csr_rdata_vld arriving outside WAIT is discarded.
- Payload inputs of non-granted requesters are don't-care.
- No response backpressure: requesters must sink rsp_vld.

## Timing
- Accept in cycle T.
- csr_rd high in T+1.
- Register block returns csr_rdata_vld in T+2.
- rsp_vld in T+3.
- Next accept no earlier than T+4. Peak throughput: 1 access / 4 cycles.
- Local reject (bad file select): rsp_vld at T+1; next accept at T+2.
- Timeout: rsp_vld at T+2+TIMEOUT_CYC.
- req_rdy is combinational from req_vld and rr_ptr, and only in IDLE.
- All other outputs are registered or decoded from state.
- Reset values:
  - state IDLE, rr_ptr 0, counter 0.
  - req_rdy 0, rsp_vld 0, rsp_rdata 0, rsp_illegal 0.
  - All csr_* outputs 0.
- rst asserted mid-transaction: abort with no response, return to IDLE, rr_ptr 0. A stale csr_rdata_vld in the following cycle is discarded.
- Simultaneous requests: exactly one grant per IDLE cycle; losers stay pending. Starvation-free, since every requester is served within NR_REQ transactions.
- rr_ptr advances only in RESP, including reject and timeout responses.

## Test plan
- Single read, req 0, addr 0x70, file 1; model returns vld at T+2 with rdata=1 -> csr_rd only at T+1, rsp_vld[0] at T+3, rsp_rdata=1, rsp_illegal=0.
- Write set, req 1, addr 0xC0, op 10, wdata 0x6 -> at T+1: csr_rd=1, csr_wdata_vld=1, csr_wdata_op=10, csr_wdata=0x6; rsp_vld[1] at T+3.
- Req 0 and req 1 both valid continuously, after reset -> grants 0,1,0,1 at cycles 0,4,8,12; each req_rdy is one cycle.
- req_file_sel=7 with NR_INTP_FILES=7 -> no csr_rd, rsp_vld at T+1 with rsp_illegal=1, rsp_rdata=0.
- Model never returns csr_rdata_vld -> rsp_illegal=1 at T+6 (TIMEOUT_CYC=4). A late csr_rdata_vld at T+7 produces no rsp_vld.
- rst pulsed at T+2 of a read -> no rsp_vld, all outputs 0 the cycle after reset. Next pending req 1 is granted only after req 0 by rr_ptr=0 priority.
